// File: rtl/btn_pulse_gen.sv
// Push-button front end for the stopwatch: two-flop synchronisers, a shared
// debounce sample prescaler, one ARM/IDLE/HELD debounce FSM per button and
// registered one-clock press pulses that are never high in the same cycle.
module btn_pulse_gen #(
    parameter int CLK_DIV    = 50000,  // clk cycles per debounce sample tick (>=2)
    parameter int DB_SAMPLES = 4       // consecutive differing samples to accept (>=1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_start,
    input  logic pb_lap,
    output logic start_stop_pulse,
    output logic lap_reset_pulse,
    output logic start_level,
    output logic lap_level
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DB_SAMPLES + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

    // ARM is the post-reset state: it waits for a release before any press
    // can count, so a button held through reset never produces a pulse.
    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HELD = 2'd2
    } btn_state_t;

    typedef struct packed {
        btn_state_t    state;
        logic [CW-1:0] cnt;
        logic          req;
    } btn_step_t;

    logic          sync1_start, sync_start;
    logic          sync1_lap, sync_lap;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    btn_state_t    state_start, state_lap;
    logic [CW-1:0] cnt_start, cnt_lap;
    btn_step_t     nxt_start, nxt_lap;
    logic          pend_lap;

    // One debounce step for one button: count consecutive tick samples that
    // differ from the reference level and move the FSM once enough are seen.
    function automatic btn_step_t btn_step(input btn_state_t state,
                                           input logic [CW-1:0] cnt,
                                           input logic sync_val,
                                           input logic tick_en);
        btn_step_t r;
        logic      ref_lvl;
        // NOTE: every field gets a default first so no path through the
        // combinational logic leaves a value unassigned (no latches).
        r.state = state;
        r.cnt   = cnt;
        r.req   = 1'b0;
        ref_lvl = (state != IDLE);
        if (tick_en) begin
            if (sync_val != ref_lvl) begin
                if (cnt == CNT_LAST) begin
                    r.cnt = '0;
                    case (state)
                        ARM:     r.state = IDLE;
                        IDLE: begin
                            r.state = HELD;
                            r.req   = 1'b1;
                        end
                        HELD:    r.state = IDLE;
                        default: r.state = ARM;
                    endcase
                end else begin
                    r.cnt = cnt + CW'(1);
                end
            end else begin
                r.cnt = '0;
            end
        end
        return r;
    endfunction

    // Two-flop synchronisers for the asynchronous raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_start <= 1'b0;
            sync_start  <= 1'b0;
            sync1_lap   <= 1'b0;
            sync_lap    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the old
            // values on the same edge, giving a true two-flop chain.
            sync1_start <= pb_start;
            sync_start  <= sync1_start;
            sync1_lap   <= pb_lap;
            sync_lap    <= sync1_lap;
        end
    end

    // Free-running sample prescaler, 0..CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_MAX);

    // Debounce FSM state and sample counters for both buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_start <= ARM;
            state_lap   <= ARM;
            cnt_start   <= '0;
            cnt_lap     <= '0;
        end else begin
            state_start <= nxt_start.state;
            state_lap   <= nxt_lap.state;
            cnt_start   <= nxt_start.cnt;
            cnt_lap     <= nxt_lap.cnt;
        end
    end

    // Next-state, counter and press-request logic for both buttons.
    always_comb begin
        nxt_start = btn_step(state_start, cnt_start, sync_start, tick);
        nxt_lap   = btn_step(state_lap, cnt_lap, sync_lap, tick);
    end

    // Registered levels and pulses; a coincident lap request is deferred one
    // clock through pend_lap. The next edge is never a tick (CLK_DIV>=2), so
    // no new start request can collide with the deferred lap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_level      <= 1'b0;
            lap_level        <= 1'b0;
            start_stop_pulse <= 1'b0;
            lap_reset_pulse  <= 1'b0;
            pend_lap         <= 1'b0;
        end else begin
            start_level      <= (nxt_start.state == HELD);
            lap_level        <= (nxt_lap.state == HELD);
            start_stop_pulse <= nxt_start.req;
            lap_reset_pulse  <= pend_lap | (nxt_lap.req & ~nxt_start.req);
            pend_lap         <= nxt_lap.req & nxt_start.req;
        end
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed scenarios followed by
// random button activity, compared every clock against a sample-history
// reference model.
module tb_btn_pulse_gen;

    localparam int CLK_DIV = 4;
    localparam int DB      = 3;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic pb_start = 1'b0;
    logic pb_lap   = 1'b0;
    logic start_stop_pulse, lap_reset_pulse, start_level, lap_level;

    btn_pulse_gen #(.CLK_DIV(CLK_DIV), .DB_SAMPLES(DB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pb_start         (pb_start),
        .pb_lap           (pb_lap),
        .start_stop_pulse (start_stop_pulse),
        .lap_reset_pulse  (lap_reset_pulse),
        .start_level      (start_level),
        .lap_level        (lap_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: clocks since reset, raw-input delay line, the list of
    // tick samples seen since reset, and the accepted level per button.
    int  k;
    bit  d1_s, d2_s, d1_l, d2_l;
    bit  armed_s, armed_l, lvl_s, lvl_l;
    bit  hist_s[$];
    bit  hist_l[$];
    bit  pend;
    bit  exp_sp, exp_lp, exp_sl, exp_ll;
    int  n_sp, n_lp;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        k = 0;
        d1_s = 0; d2_s = 0; d1_l = 0; d2_l = 0;
        armed_s = 1; armed_l = 1; lvl_s = 0; lvl_l = 0;
        hist_s.delete();
        hist_l.delete();
        pend = 0;
        exp_sp = 0; exp_lp = 0; exp_sl = 0; exp_ll = 0;
    endtask

    // A change is accepted when the last DB tick samples all differ from the
    // reference level (1 while armed, otherwise the accepted level).
    function automatic bit window_differs(input bit q[$], input bit r);
        if (q.size() < DB) return 1'b0;
        for (int i = 1; i <= DB; i++)
            if (q[q.size() - i] == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit tick, sv_s, sv_l, req_s, req_l;
        if (!rst_n) return;
        tick = ((k % CLK_DIV) == CLK_DIV - 1);
        sv_s = d2_s; d2_s = d1_s; d1_s = pb_start;
        sv_l = d2_l; d2_l = d1_l; d1_l = pb_lap;
        req_s = 0; req_l = 0;
        if (tick) begin
            hist_s.push_back(sv_s);
            hist_l.push_back(sv_l);
            if (window_differs(hist_s, armed_s ? 1'b1 : lvl_s)) begin
                if (armed_s) armed_s = 0;
                else begin lvl_s = !lvl_s; req_s = lvl_s; end
            end
            if (window_differs(hist_l, armed_l ? 1'b1 : lvl_l)) begin
                if (armed_l) armed_l = 0;
                else begin lvl_l = !lvl_l; req_l = lvl_l; end
            end
        end
        exp_sp = req_s;
        exp_lp = pend | (req_l & ~req_s);
        pend   = req_l & req_s;
        exp_sl = lvl_s;
        exp_ll = lvl_l;
        k++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_start_pulse"}, start_stop_pulse, exp_sp);
        check({tag, "_lap_pulse"}, lap_reset_pulse, exp_lp);
        check({tag, "_start_level"}, start_level, exp_sl);
        check({tag, "_lap_level"}, lap_level, exp_ll);
        check({tag, "_exclusive"}, start_stop_pulse & lap_reset_pulse, 1'b0);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cyc(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs(tag);
            if (start_stop_pulse === 1'b1) n_sp++;
            if (lap_reset_pulse === 1'b1) n_lp++;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        cyc(tag, 3);
        rst_n = 1'b1;
    endtask

    initial begin
        n_sp = 0; n_lp = 0;
        model_reset();
        #1;
        check_outputs("por");
        @(negedge clk);
        cyc("por_hold", 2);
        rst_n = 1'b1;

        // Both buttons low after reset: arm completes, no pulses.
        cyc("t1", 16);
        check_int("t1_pulses", n_sp + n_lp, 0);
        check("t1_start_idle", start_level, 1'b0);

        // Clean long start press.
        n_sp = 0; n_lp = 0;
        pb_start = 1'b1;
        cyc("t2_hold", 40);
        check("t2_level_held", start_level, 1'b1);
        pb_start = 1'b0;
        cyc("t2_rel", 20);
        check_int("t2_start_pulses", n_sp, 1);
        check_int("t2_lap_pulses", n_lp, 0);

        // Lap button bouncing 1,0,1 over tick periods, then held.
        n_sp = 0; n_lp = 0;
        pb_lap = 1'b1; cyc("t3_b1", CLK_DIV);
        pb_lap = 1'b0; cyc("t3_b0", CLK_DIV);
        pb_lap = 1'b1; cyc("t3_hold", 40);
        pb_lap = 1'b0; cyc("t3_rel", 20);
        check_int("t3_lap_pulses", n_lp, 1);

        // Simultaneous press of both buttons.
        n_sp = 0; n_lp = 0;
        pb_start = 1'b1; pb_lap = 1'b1;
        cyc("t4_hold", 40);
        pb_start = 1'b0; pb_lap = 1'b0;
        cyc("t4_rel", 20);
        check_int("t4_start_pulses", n_sp, 1);
        check_int("t4_lap_pulses", n_lp, 1);

        // Start held through reset release: ignored until released and re-pressed.
        n_sp = 0; n_lp = 0;
        pb_start = 1'b1;
        do_reset("t5_rst");
        cyc("t5_hold", 50);
        check_int("t5_no_pulse", n_sp, 0);
        pb_start = 1'b0; cyc("t5_rel", 20);
        pb_start = 1'b1; cyc("t5_press", 30);
        check_int("t5_one_pulse", n_sp, 1);
        pb_start = 1'b0; cyc("t5_rel2", 20);

        // Reset while in HELD.
        pb_start = 1'b1;
        cyc("t6_hold", 30);
        check("t6_level_before", start_level, 1'b1);
        do_reset("t6_rst");
        check("t6_level_after", start_level, 1'b0);
        cyc("t6_after", 30);
        pb_start = 1'b0;
        cyc("t6_rel", 20);

        // Random bouncing buttons with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) pb_start = ~pb_start;
            if ($urandom_range(0, 11) == 0) pb_lap = ~pb_lap;
            if ($urandom_range(0, 999) == 0) do_reset("rnd_rst");
            cyc("rnd", 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
